// File: rtl/pzcorebus_request_arbiter.sv
// Round-robin N-to-1 arbiter for the corebus request side (command plus write data).
// A write command keeps its grant until its last data beat, so bursts never interleave.
module pzcorebus_request_arbiter #(
    parameter int N      = 4,
    parameter int CMD_W  = 64,
    parameter int DATA_W = 64,
    parameter int IDX_W  = $clog2(N)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [N-1:0]        i_mcmd_valid,
    output logic [N-1:0]        o_scmd_accept,
    input  logic [N*CMD_W-1:0]  i_mcmd,
    input  logic [N-1:0]        i_mcmd_write,
    input  logic [N-1:0]        i_mdata_valid,
    output logic [N-1:0]        o_sdata_accept,
    input  logic [N*DATA_W-1:0] i_mdata,
    input  logic [N-1:0]        i_mdata_last,
    output logic                o_mcmd_valid,
    input  logic                i_scmd_accept,
    output logic [CMD_W-1:0]    o_mcmd,
    output logic [IDX_W-1:0]    o_mcmd_source,
    output logic                o_mdata_valid,
    input  logic                i_sdata_accept,
    output logic [DATA_W-1:0]   o_mdata,
    output logic                o_mdata_last
);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_e;

    localparam logic [IDX_W:0]   REQ_COUNT = (IDX_W+1)'(N);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N-1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;

    logic [N-1:0]       rotReq;
    logic [IDX_W-1:0]   offset;
    logic [IDX_W:0]     pickSum;
    logic [IDX_W-1:0]   pick;

    logic               cmdValidSel, cmdWriteSel;
    logic [CMD_W-1:0]   cmdSel;
    logic               dataValidSel, dataLastSel;
    logic [DATA_W-1:0]  dataSel;

    // Rotate requests so bit 0 is the requester at the pointer; the first set bit wins.
    assign rotReq  = N'({i_mcmd_valid, i_mcmd_valid} >> ptr_q);
    assign pickSum = {1'b0, ptr_q} + {1'b0, offset};
    assign pick    = (pickSum >= REQ_COUNT) ? IDX_W'(pickSum - REQ_COUNT) : pickSum[IDX_W-1:0];

    always_comb begin
        offset = '0;
        for (int i = N-1; i >= 0; i--) begin
            if (rotReq[i]) begin
                offset = IDX_W'(i);
            end
        end
    end

    always_comb begin
        cmdValidSel  = 1'b0;
        cmdWriteSel  = 1'b0;
        cmdSel       = '0;
        dataValidSel = 1'b0;
        dataLastSel  = 1'b0;
        dataSel      = '0;
        for (int k = 0; k < N; k++) begin
            if (grant_q == IDX_W'(k)) begin
                cmdValidSel  = i_mcmd_valid[k];
                cmdWriteSel  = i_mcmd_write[k];
                cmdSel       = i_mcmd[k*CMD_W +: CMD_W];
                dataValidSel = i_mdata_valid[k];
                dataLastSel  = i_mdata_last[k];
                dataSel      = i_mdata[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        ptr_d          = ptr_q;
        o_scmd_accept  = '0;
        o_sdata_accept = '0;
        o_mcmd_valid   = 1'b0;
        o_mcmd         = '0;
        o_mcmd_source  = '0;
        o_mdata_valid  = 1'b0;
        o_mdata        = '0;
        o_mdata_last   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|i_mcmd_valid) begin
                    grant_d = pick;
                    state_d = CMD;
                end
            end
            CMD: begin
                o_mcmd_valid           = cmdValidSel;
                o_mcmd                 = cmdValidSel ? cmdSel : '0;
                o_mcmd_source          = cmdValidSel ? grant_q : '0;
                o_scmd_accept[grant_q] = i_scmd_accept & cmdValidSel;
                if (cmdValidSel && i_scmd_accept) begin
                    ptr_d   = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
                    state_d = cmdWriteSel ? DATA : IDLE;
                end
            end
            DATA: begin
                o_mdata_valid           = dataValidSel;
                o_mdata                 = dataValidSel ? dataSel : '0;
                o_mdata_last            = dataValidSel & dataLastSel;
                o_sdata_accept[grant_q] = i_sdata_accept & dataValidSel;
                if (dataValidSel && i_sdata_accept && dataLastSel) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    validExclusive: assert property (@(posedge i_clk) disable iff (i_rst)
        !(o_mcmd_valid && o_mdata_valid));
    acceptOneHot: assert property (@(posedge i_clk) disable iff (i_rst)
        $onehot0(o_scmd_accept) && $onehot0(o_sdata_accept));
    grantStable: assert property (@(posedge i_clk) disable iff (i_rst)
        (state_q != IDLE) |=> $stable(grant_q));

endmodule

// File: tb/tb_pzcorebus_request_arbiter.sv
// Scoreboard bench for pzcorebus_request_arbiter: masters modelled per requester,
// expected commands/beats queued in predicted grant order and popped on slave handshakes.
module tb_pzcorebus_request_arbiter;

    localparam int N      = 4;
    localparam int CMD_W  = 64;
    localparam int DATA_W = 64;
    localparam int IDX_W  = 2;

    typedef struct packed {
        logic [IDX_W-1:0] src;
        logic [63:0]      cmd;
    } expCmd_t;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } expData_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        iMcmdValid;
    logic [N-1:0]        oScmdAccept;
    logic [N*CMD_W-1:0]  iMcmd;
    logic [N-1:0]        iMcmdWrite;
    logic [N-1:0]        iMdataValid;
    logic [N-1:0]        oSdataAccept;
    logic [N*DATA_W-1:0] iMdata;
    logic [N-1:0]        iMdataLast;
    logic                oMcmdValid;
    logic                iScmdAccept;
    logic [CMD_W-1:0]    oMcmd;
    logic [IDX_W-1:0]    oMcmdSource;
    logic                oMdataValid;
    logic                iSdataAccept;
    logic [DATA_W-1:0]   oMdata;
    logic                oMdataLast;

    logic [63:0] cmdPay [N];
    logic [63:0] dataPay [N];
    int          beatIdx [N];
    int          beatTotal [N];
    int          reqTag [N];
    int          tagCounter = 0;
    bit          randData = 1'b0;

    expCmd_t     expCmdQ [$];
    expData_t    expDataQ [$];

    int testsRun = 0;
    int testsFailed = 0;
    int cycleNo = 0;

    logic             sMcmdValid, sMdataValid, sMdataLast;
    logic [IDX_W-1:0] sMcmdSource;
    logic [63:0]      sMcmd, sMdata;
    logic [N-1:0]     sScmdAccept, sSdataAccept;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            iMcmd[k*CMD_W +: CMD_W]   = cmdPay[k];
            iMdata[k*DATA_W +: DATA_W] = dataPay[k];
        end
    end

    pzcorebus_request_arbiter #(
        .N(N), .CMD_W(CMD_W), .DATA_W(DATA_W), .IDX_W(IDX_W)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_mcmd_valid   (iMcmdValid),
        .o_scmd_accept  (oScmdAccept),
        .i_mcmd         (iMcmd),
        .i_mcmd_write   (iMcmdWrite),
        .i_mdata_valid  (iMdataValid),
        .o_sdata_accept (oSdataAccept),
        .i_mdata        (iMdata),
        .i_mdata_last   (iMdataLast),
        .o_mcmd_valid   (oMcmdValid),
        .i_scmd_accept  (iScmdAccept),
        .o_mcmd         (oMcmd),
        .o_mcmd_source  (oMcmdSource),
        .o_mdata_valid  (oMdataValid),
        .i_sdata_accept (iSdataAccept),
        .o_mdata        (oMdata),
        .o_mdata_last   (oMdataLast)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mkData(input int k, input int tag, input int beat);
        return {16'(k), 16'(tag), 32'(beat)};
    endfunction

    function automatic bit mastersBusy();
        return (|iMcmdValid) || (|iMdataValid) || (expCmdQ.size() != 0) || (expDataQ.size() != 0);
    endfunction

    task automatic clearMasters();
        iMcmdValid  = '0;
        iMcmdWrite  = '0;
        iMdataValid = '0;
        iMdataLast  = '0;
        for (int k = 0; k < N; k++) begin
            cmdPay[k]    = '0;
            dataPay[k]   = '0;
            beatIdx[k]   = 0;
            beatTotal[k] = 0;
            reqTag[k]    = 0;
        end
        expCmdQ.delete();
        expDataQ.delete();
    endtask

    // A master raises its command; write masters present their first beat at the same time.
    task automatic applyStimulus(input int k, input bit write, input int beats);
        tagCounter++;
        reqTag[k]     = tagCounter;
        cmdPay[k]     = {32'hC0DE_0000 | 32'(k), 32'(tagCounter)};
        iMcmdValid[k] = 1'b1;
        iMcmdWrite[k] = write;
        if (write) begin
            beatTotal[k]   = beats;
            beatIdx[k]     = 0;
            dataPay[k]     = mkData(k, tagCounter, 0);
            iMdataLast[k]  = (beats == 1);
            iMdataValid[k] = 1'b1;
        end
    endtask

    task automatic expectTxn(input int k);
        expCmdQ.push_back('{src: IDX_W'(k), cmd: cmdPay[k]});
        if (iMcmdWrite[k]) begin
            for (int b = 0; b < beatTotal[k]; b++) begin
                expDataQ.push_back('{data: mkData(k, reqTag[k], b), last: (b == beatTotal[k] - 1)});
            end
        end
    endtask

    // One clock: sample and score at the falling edge, advance the masters just after the rising edge.
    task automatic cycle();
        expCmd_t  ec;
        expData_t ed;
        @(negedge clk);
        cycleNo++;
        sMcmdValid   = oMcmdValid;
        sMcmdSource  = oMcmdSource;
        sMcmd        = oMcmd;
        sScmdAccept  = oScmdAccept;
        sMdataValid  = oMdataValid;
        sMdata       = oMdata;
        sMdataLast   = oMdataLast;
        sSdataAccept = oSdataAccept;
        if (!rst) begin
            checkOutput("validExclusive", 64'(sMcmdValid & sMdataValid), 64'd0);
            if (!sMcmdValid) checkOutput("cmdZeroWhenIdle", sMcmd | 64'(sMcmdSource), 64'd0);
            if (!sMdataValid) checkOutput("dataZeroWhenIdle", sMdata | 64'(sMdataLast), 64'd0);
            if (sMcmdValid && iScmdAccept) begin
                if (expCmdQ.size() == 0) begin
                    checkOutput("cmdUnexpected", 64'(sMcmdSource), 64'hFF);
                end else begin
                    ec = expCmdQ.pop_front();
                    checkOutput("cmdSource", 64'(sMcmdSource), 64'(ec.src));
                    checkOutput("cmdPayload", sMcmd, ec.cmd);
                    checkOutput("cmdAcceptBit", 64'(sScmdAccept), 64'(1) << ec.src);
                end
            end else begin
                checkOutput("cmdAcceptIdle", 64'(sScmdAccept), 64'd0);
            end
            if (sMdataValid && iSdataAccept) begin
                if (expDataQ.size() == 0) begin
                    checkOutput("dataUnexpected", sMdata, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    ed = expDataQ.pop_front();
                    checkOutput("dataPayload", sMdata, ed.data);
                    checkOutput("dataLast", 64'(sMdataLast), 64'(ed.last));
                end
            end else begin
                checkOutput("dataAcceptIdle", 64'(sSdataAccept), 64'd0);
            end
        end
        @(posedge clk);
        #1;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                if (sScmdAccept[k]) iMcmdValid[k] = 1'b0;
                if (sSdataAccept[k]) begin
                    beatIdx[k]++;
                    if (beatIdx[k] >= beatTotal[k]) begin
                        iMdataValid[k] = 1'b0;
                        iMdataLast[k]  = 1'b0;
                        dataPay[k]     = '0;
                    end else begin
                        dataPay[k]    = mkData(k, reqTag[k], beatIdx[k]);
                        iMdataLast[k] = (beatIdx[k] == beatTotal[k] - 1);
                    end
                end
            end
            if (randData) iSdataAccept = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (mastersBusy() && n < budget) begin
            cycle();
            n++;
        end
        checkOutput({tag, "Drained"}, 64'(mastersBusy()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int hsCount, prevHs, lastBeatCycle, firstCmdCycle, earlyAccept, waitCycles, beats;
        bit granted;

        rst = 1'b1;
        iScmdAccept = 1'b1;
        iSdataAccept = 1'b1;
        clearMasters();
        iMcmdValid = '1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetCmdValid", 64'(oMcmdValid), 64'd0);
        checkOutput("resetDataValid", 64'(oMdataValid), 64'd0);
        checkOutput("resetAccepts", 64'({oScmdAccept, oSdataAccept}), 64'd0);
        clearMasters();
        @(negedge clk);
        rst = 1'b0;

        // Round robin: all four read, requester 0 re-requests after its first grant.
        for (int k = 0; k < N; k++) applyStimulus(k, 1'b0, 0);
        for (int k = 0; k < N; k++) expectTxn(k);
        hsCount = 0;
        prevHs = -1;
        for (int n = 0; n < 40 && hsCount < 5; n++) begin
            cycle();
            if (sMcmdValid && iScmdAccept) begin
                hsCount++;
                if (prevHs >= 0) checkOutput("rrSpacing", 64'(cycleNo - prevHs), 64'd2);
                prevHs = cycleNo;
                if (hsCount == 1) begin
                    applyStimulus(0, 1'b0, 0);
                    expectTxn(0);
                end
            end
        end
        checkOutput("rrCount", 64'(hsCount), 64'd5);
        drain("rr", 20);

        // Slave stalls the command for five cycles.
        iScmdAccept = 1'b0;
        applyStimulus(1, 1'b0, 0);
        expectTxn(1);
        cycle();
        checkOutput("stallBubble", 64'(sMcmdValid), 64'd0);
        for (int n = 0; n < 5; n++) begin
            cycle();
            checkOutput("stallValid", 64'(sMcmdValid), 64'd1);
            checkOutput("stallSource", 64'(sMcmdSource), 64'd1);
            checkOutput("stallPayload", sMcmd, cmdPay[1]);
            checkOutput("stallAccept", 64'(sScmdAccept), 64'd0);
        end
        iScmdAccept = 1'b1;
        cycle();
        checkOutput("stallRelease", 64'(sScmdAccept), 64'b0010);
        cycle();
        checkOutput("stallSingle", 64'(sMcmdValid), 64'd0);
        drain("stall", 10);

        // Requester 2 writes four beats; requester 1's read must wait for the last beat.
        applyStimulus(2, 1'b1, 4);
        expectTxn(2);
        granted = 1'b0;
        for (int n = 0; n < 20 && !granted; n++) begin
            cycle();
            if (sScmdAccept[2]) granted = 1'b1;
        end
        checkOutput("holdGrant2", 64'(granted), 64'd1);
        applyStimulus(1, 1'b0, 0);
        expectTxn(1);
        lastBeatCycle = -1;
        firstCmdCycle = -1;
        for (int n = 0; n < 30 && firstCmdCycle < 0; n++) begin
            cycle();
            if (sMdataValid && iSdataAccept && sMdataLast) lastBeatCycle = cycleNo;
            if (sMcmdValid) begin
                firstCmdCycle = cycleNo;
                checkOutput("holdSource", 64'(sMcmdSource), 64'd1);
            end
        end
        checkOutput("holdLatency", 64'(firstCmdCycle - lastBeatCycle), 64'd2);
        drain("hold", 20);

        // Requester 3 shows write data long before its command is granted.
        iScmdAccept = 1'b0;
        randData = 1'b1;
        applyStimulus(2, 1'b0, 0);
        applyStimulus(3, 1'b1, 3);
        expectTxn(2);
        expectTxn(3);
        earlyAccept = 0;
        waitCycles = 0;
        for (int n = 0; n < 80 && mastersBusy(); n++) begin
            cycle();
            if (n == 3) iScmdAccept = 1'b1;
            if (!sMdataValid && iMdataValid[3]) waitCycles++;
            if (!sMdataValid && sSdataAccept[3]) earlyAccept++;
        end
        randData = 1'b0;
        iSdataAccept = 1'b1;
        checkOutput("earlyDataAccept", 64'(earlyAccept), 64'd0);
        checkOutput("dataWaited", 64'(waitCycles >= 3), 64'd1);
        drain("early", 20);

        // Reset in the middle of a four-beat burst.
        applyStimulus(2, 1'b1, 4);
        expectTxn(2);
        beats = 0;
        for (int n = 0; n < 20 && beats < 2; n++) begin
            cycle();
            if (sSdataAccept[2]) beats++;
        end
        checkOutput("midBurstBeats", 64'(beats), 64'd2);
        rst = 1'b1;
        #1;
        checkOutput("rstMidValid", 64'({oMcmdValid, oMdataValid}), 64'd0);
        checkOutput("rstMidAccept", 64'({oScmdAccept, oSdataAccept}), 64'd0);
        checkOutput("rstMidPayload", oMcmd | oMdata | 64'(oMcmdSource) | 64'(oMdataLast), 64'd0);
        clearMasters();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(3, 1'b0, 0);
        applyStimulus(0, 1'b0, 0);
        expectTxn(0);
        expectTxn(3);
        drain("postReset", 30);

        // Pointer wrap: serve 2 so the pointer sits at 3, then 0 and 3 compete.
        applyStimulus(2, 1'b0, 0);
        expectTxn(2);
        drain("wrapSetup", 20);
        applyStimulus(0, 1'b0, 0);
        applyStimulus(3, 1'b0, 0);
        expectTxn(3);
        expectTxn(0);
        drain("wrap", 30);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/pzcorebus_request_arbiter.md
Name: pzcorebus_request_arbiter

Overview:
- N-to-1 arbiter for the request side of a corebus: command channel plus write-data channel.
- Grants one requester at a time, round-robin, and forwards its command.
- For write commands, the grant is held until the last write-data beat is accepted, so data beats never interleave between requesters.
- Sits between several masters (including tie-off/dummy masters driving all-zero) and a single slave port. Response routing is out of scope.

Parameters:
- N, 4, number of requesters; 2..16.
- CMD_W, 64, width of the opaque command payload.
- DATA_W, 64, width of the opaque write-data payload.
- IDX_W, $clog2(N), width of the source index.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  asynchronous active-high reset
- i_mcmd_valid  input  N  per-requester command valid
- o_scmd_accept  output  N  per-requester command accept
- i_mcmd  input  N*CMD_W  per-requester command; slice k = [k*CMD_W +: CMD_W]
- i_mcmd_write  input  N  per-requester flag: command carries write data
- i_mdata_valid  input  N  per-requester write-data valid
- o_sdata_accept  output  N  per-requester write-data accept
- i_mdata  input  N*DATA_W  per-requester write data; slice k = [k*DATA_W +: DATA_W]
- i_mdata_last  input  N  per-requester last beat of burst
- o_mcmd_valid  output  1  command valid to slave
- i_scmd_accept  input  1  command accept from slave
- o_mcmd  output  CMD_W  muxed command
- o_mcmd_source  output  IDX_W  index of the granted requester
- o_mdata_valid  output  1  write-data valid to slave
- i_sdata_accept  input  1  write-data accept from slave
- o_mdata  output  DATA_W  muxed write data
- o_mdata_last  output  1  muxed last flag

Behaviour:
- Registered state: state ∈ {IDLE, CMD, DATA}; grant index g; round-robin pointer p.
- Async reset: state=IDLE, g=0, p=0.
  - All valid/accept outputs are 0 during and after reset until the first grant.
  - o_mcmd, o_mdata, o_mdata_last and o_mcmd_source read 0 whenever their valid is 0.
- IDLE:
  - All outputs low.
  - If any i_mcmd_valid bit is set: g = first set index searching p, p+1, …, N-1, 0, …, p-1 (wrap). Next state CMD.
  - This costs a fixed 1-cycle arbitration bubble.
- CMD:
  - o_mcmd_valid = i_mcmd_valid[g]; o_mcmd = slice g; o_mcmd_source = g.
  - o_scmd_accept[g] = i_scmd_accept & i_mcmd_valid[g]; all other accept bits 0.
  - On the handshake (valid & accept): p = (g == N-1) ? 0 : g+1.
  - Next state is DATA if i_mcmd_write[g], else IDLE.
  - Without the handshake, stay in CMD and keep g; the grant is never revoked.
- DATA:
  - o_mdata_valid = i_mdata_valid[g]; o_mdata and o_mdata_last = slice g.
  - o_sdata_accept[g] = i_sdata_accept & i_mdata_valid[g]; all other accept bits 0.
  - Handshake with last=1 → IDLE. Any other beat → stay in DATA.
  - o_mcmd_valid = 0 throughout DATA.
- Write data is forwarded only in DATA. Data a requester presents before its command is granted is held off (accept=0).
- Requests arriving while the block is in CMD or DATA wait. No starvation: each requester is served within N grants.
- Single-beat write: the command handshake moves to DATA, then one beat with last=1 returns to IDLE.
- Combinational paths: i_scmd_accept→o_scmd_accept and i_sdata_accept→o_sdata_accept. No path from accept to valid.
- Assertions:
  - o_mcmd_valid and o_mdata_valid are never both 1.
  - At most one o_scmd_accept bit and one o_sdata_accept bit are set.
  - g is stable outside IDLE.

Test Plan:
- Reset mid-burst: assert i_rst in DATA after 2 of 4 beats → all outputs 0 immediately, state IDLE, p=0; after release, requester 0 wins first.
- All 4 requesters issue reads, i_scmd_accept=1 → o_mcmd_source sequence 0,1,2,3,0; one command per 2 cycles.
- Requester 2 writes a 4-beat burst while requester 1 requests a read → requester 2 keeps the grant through beat 4 (last). Requester 1's command appears 2 cycles after the last-beat handshake.
- Slave stalls: i_scmd_accept=0 for 5 cycles → o_mcmd and o_mcmd_source stable, o_scmd_accept all 0. Accept on cycle 6 → single handshake.
- Data before command: requester 3 raises data valid 3 cycles before its command is granted → o_sdata_accept[3]=0 until the DATA state. Beats arrive at the slave in order, none lost or duplicated.
- Pointer wrap: with p=3, requesters 0 and 3 both request → 3 granted first, then 0.
